// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: STAGES slices, each a ripple of BLOCK-bit lookahead
// groups, with a single global advance signal for valid/ready flow control.
module pipelined_cla_adder #(
    parameter int WIDTH  = 64,
    parameter int BLOCK  = 4,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int S    = WIDTH / STAGES;
    localparam int NGRP = S / BLOCK;
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || BLOCK < 1 || WIDTH % (BLOCK * STAGES) != 0) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK*STAGES");
    end

    typedef struct packed {
        logic [S-1:0] sum;
        logic         cout;
        logic         cmsb;
    } slice_t;

    // Bit carries inside a group come from the group's running G/P; groups ripple into each other.
    function automatic slice_t cla_slice(input logic [S-1:0] x, input logic [S-1:0] y,
                                         input logic ci);
        slice_t           r;
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic             grp_g;
        logic             grp_p;
        logic             c_grp;
        logic             c_bit;
        r     = '0;
        c_grp = ci;
        c_bit = ci;
        for (int j = 0; j < NGRP; j++) begin
            g     = x[j*BLOCK +: BLOCK] & y[j*BLOCK +: BLOCK];
            p     = x[j*BLOCK +: BLOCK] ^ y[j*BLOCK +: BLOCK];
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                c_bit              = grp_g | (grp_p & c_grp);
                r.sum[j*BLOCK + i] = p[i] ^ c_bit;
                grp_g              = g[i] | (p[i] & grp_g);
                grp_p              = grp_p & p[i];
            end
            c_grp = grp_g | (grp_p & c_grp);
        end
        r.cout = c_grp;
        r.cmsb = c_bit;
        return r;
    endfunction

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [STAGES-1:0] cry_q;
    logic [STAGES-1:0] cry_d;
    logic [STAGES-1:0] ovf_q;
    logic [STAGES-1:0] ovf_d;
    slice_t            res   [STAGES];
    logic [WIDTH-1:0]  b_eff;
    logic              c_eff;
    logic              advance;

    always_comb begin
        // Subtraction is folded in at the input: a + ~b + !c_in.
        b_eff   = sub ? ~b : b;
        c_eff   = sub ? ~c_in : c_in;
        advance = out_ready | ~vld_q[LAST];

        res[0]          = cla_slice(a[S-1:0], b_eff[S-1:0], c_eff);
        vld_d[0]        = in_valid;
        a_d[0]          = a;
        b_d[0]          = b_eff;
        sum_d[0]        = '0;
        sum_d[0][S-1:0] = res[0].sum;
        cry_d[0]        = res[0].cout;
        ovf_d[0]        = res[0].cout ^ res[0].cmsb;

        for (int k = 1; k < STAGES; k++) begin
            res[k]             = cla_slice(a_q[k-1][k*S +: S], b_q[k-1][k*S +: S], cry_q[k-1]);
            vld_d[k]           = vld_q[k-1];
            a_d[k]             = a_q[k-1];
            b_d[k]             = b_q[k-1];
            sum_d[k]           = sum_q[k-1];
            sum_d[k][k*S +: S] = res[k].sum;
            cry_d[k]           = res[k].cout;
            ovf_d[k]           = res[k].cout ^ res[k].cmsb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cry_q <= '0;
            ovf_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= vld_d;
            cry_q <= cry_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign in_ready  = advance;
    assign out_valid = vld_q[LAST];
    assign sum       = sum_q[LAST];
    assign c_out     = cry_q[LAST];
    assign ovf       = ovf_q[LAST];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed vector table, async reset, random streams with and
// without backpressure against an arithmetic reference model, and two smaller parameter sets.
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
    logic [63:0] a, b, sum;

    logic        in_valid_n, c_in_n, sub_n, out_ready_n;
    logic [31:0] a_n, b_n;
    logic        in_ready2, out_valid2, c_out2, ovf2;
    logic [31:0] sum2;
    logic        in_ready1, out_valid1, c_out1, ovf1;
    logic [31:0] sum1;

    pipelined_cla_adder #(.WIDTH(64), .BLOCK(4), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .c_out(c_out), .ovf(ovf));

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(8), .STAGES(2)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid_n), .in_ready(in_ready2), .a(a_n), .b(b_n),
        .c_in(c_in_n), .sub(sub_n), .out_valid(out_valid2), .out_ready(out_ready_n), .sum(sum2),
        .c_out(c_out2), .ovf(ovf2));

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_n), .in_ready(in_ready1), .a(a_n), .b(b_n),
        .c_in(c_in_n), .sub(sub_n), .out_valid(out_valid1), .out_ready(out_ready_n), .sum(sum1),
        .c_out(c_out1), .ovf(ovf1));

    int checks   = 0;
    int failures = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    // Reference: plain wide arithmetic; overflow from the true signed result's range.
    function automatic res_t ref_model(input logic [63:0] x, input logic [63:0] y,
                                       input logic ci, input logic s);
        res_t        r;
        logic [64:0] ux;
        logic [65:0] sx, sy, sr;
        sx = {{2{x[63]}}, x};
        sy = {{2{y[63]}}, y};
        if (!s) begin
            ux     = {1'b0, x} + {1'b0, y} + {64'd0, ci};
            r.sum  = ux[63:0];
            r.cout = ux[64];
            sr     = sx + sy + {65'd0, ci};
        end else begin
            r.sum  = x - y - {63'd0, ci};
            r.cout = ({1'b0, x} >= ({1'b0, y} + {64'd0, ci}));
            sr     = sx - sy - {65'd0, ci};
        end
        r.ovf = (sr[65:63] != 3'b000) && (sr[65:63] != 3'b111);
        return r;
    endfunction

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        ci;
        logic        s;
        logic [63:0] esum;
        logic        ecout;
        logic        eovf;
    } vec_t;

    res_t exp_q[$];

    task automatic apply_vec(input vec_t v);
        int edges;
        in_valid  = 1'b1;
        a         = v.a;
        b         = v.b;
        c_in      = v.ci;
        sub       = v.s;
        out_ready = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        in_valid = 1'b0;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            #1;
        end
        check_int({v.name, "_latency"}, edges, 4);
        check64({v.name, "_sum"}, sum, v.esum);
        check1({v.name, "_cout"}, c_out, v.ecout);
        check1({v.name, "_ovf"}, ovf, v.eovf);
    endtask

    task automatic rand_operands();
        a    = {$urandom, $urandom};
        b    = {$urandom, $urandom};
        c_in = 1'($urandom_range(1));
        sub  = 1'($urandom_range(1));
        case ($urandom_range(3))
            0: b = ~a;
            1: a = 64'hFFFF_FFFF_FFFF_FFFF >> $urandom_range(63);
            default: ;
        endcase
    endtask

    task automatic run_random(input string tag, input int n, input int rdy_pct);
        int          sent = 0, got = 0, cyc = 0, stalled_in = 0;
        logic        held = 1'b0, xfer;
        logic [63:0] h_sum;
        logic        h_cout, h_ovf;
        res_t        e, nxt;
        while ((sent < n || got < sent) && cyc < 20 * n + 100) begin
            in_valid = (sent < n);
            rand_operands();
            out_ready = ($urandom_range(99) < rdy_pct);
            nxt = ref_model(a, b, c_in, sub);
            #3;
            if (held) begin
                check1({tag, "_hold_valid"}, out_valid, 1'b1);
                check64({tag, "_hold_sum"}, sum, h_sum);
                check1({tag, "_hold_cout"}, c_out, h_cout);
                check1({tag, "_hold_ovf"}, ovf, h_ovf);
            end
            check1({tag, "_in_ready"}, in_ready, out_ready | ~out_valid);
            if (out_valid && out_ready) begin
                check1({tag, "_unexpected_out"}, exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check64({tag, "_sum"}, sum, e.sum);
                    check1({tag, "_cout"}, c_out, e.cout);
                    check1({tag, "_ovf"}, ovf, e.ovf);
                end
                got++;
            end
            held   = out_valid && !out_ready;
            h_sum  = sum;
            h_cout = c_out;
            h_ovf  = ovf;
            xfer   = in_valid && in_ready;
            if (in_valid && !in_ready) stalled_in++;
            @(posedge clk);
            #1;
            cyc++;
            if (xfer) begin
                exp_q.push_back(nxt);
                sent++;
            end
        end
        in_valid = 1'b0;
        check_int({tag, "_sent"}, sent, n);
        check_int({tag, "_received"}, got, n);
        check_int({tag, "_leftover"}, exp_q.size(), 0);
        if (rdy_pct == 100) check_int({tag, "_input_stalls"}, stalled_in, 0);
        exp_q.delete();
    endtask

    task automatic run_small(input string tag, input logic [31:0] x, input logic [31:0] y,
                             input logic ci, input logic s, input logic [31:0] esum,
                             input logic ecout, input logic eovf);
        int          edges, lat2 = 0, lat1 = 0;
        logic [31:0] s2 = '0, s1 = '0;
        logic        c2 = 1'b0, c1 = 1'b0, o2 = 1'b0, o1 = 1'b0;
        in_valid_n  = 1'b1;
        a_n         = x;
        b_n         = y;
        c_in_n      = ci;
        sub_n       = s;
        out_ready_n = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        in_valid_n = 1'b0;
        while ((lat2 == 0 || lat1 == 0) && edges < 10) begin
            if (out_valid2 && lat2 == 0) begin
                lat2 = edges; s2 = sum2; c2 = c_out2; o2 = ovf2;
            end
            if (out_valid1 && lat1 == 0) begin
                lat1 = edges; s1 = sum1; c1 = c_out1; o1 = ovf1;
            end
            if (lat2 == 0 || lat1 == 0) begin
                @(posedge clk);
                edges++;
                #1;
            end
        end
        check_int({tag, "_s2_latency"}, lat2, 2);
        check_int({tag, "_s1_latency"}, lat1, 1);
        check64({tag, "_s2_sum"}, {32'd0, s2}, {32'd0, esum});
        check64({tag, "_s1_sum"}, {32'd0, s1}, {32'd0, esum});
        check1({tag, "_s2_cout"}, c2, ecout);
        check1({tag, "_s1_cout"}, c1, ecout);
        check1({tag, "_s2_ovf"}, o2, eovf);
        check1({tag, "_s1_ovf"}, o1, eovf);
        repeat (3) @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];
    int   waited;

    initial begin
        vecs[0] = '{"add_all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
        vecs[1] = '{"sub_min_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[2] = '{"add_max_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{"sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{"sub_borrow_in", 64'd0, 64'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vecs[5] = '{"add_cin_slices", 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
                    64'h0000_0001_0000_0000, 1'b0, 1'b0};
        vecs[6] = '{"add_mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
                    64'h2222_2222_2222_2211, 1'b0, 1'b0};
        vecs[7] = '{"add_neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                    64'd0, 1'b1, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid_n = 1'b0; a_n = '0; b_n = '0; c_in_n = 1'b0; sub_n = 1'b0; out_ready_n = 1'b1;
        #1;
        check1("reset_out_valid", out_valid, 1'b0);
        check64("reset_sum", sum, 64'd0);
        check1("reset_cout", c_out, 1'b0);
        check1("reset_ovf", ovf, 1'b0);
        #12;
        rst = 1'b0;
        #1;
        check1("post_reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) apply_vec(vecs[i]);
        repeat (5) @(posedge clk);
        #1;

        // Reset with work in flight: output must drop without a clock edge.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 64'd100 + 64'(i);
            b = 64'd1;
            c_in = 1'b0;
            sub = 1'b0;
            @(posedge clk);
            #1;
        end
        waited = 0;
        while (!out_valid && waited < 10) begin
            @(posedge clk);
            waited++;
            #1;
        end
        check1("midreset_pre_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check1("midreset_out_valid", out_valid, 1'b0);
        check64("midreset_sum", sum, 64'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check1("midreset_in_ready", in_ready, 1'b1);
        waited = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) waited++;
        end
        check_int("midreset_discarded", waited, 0);

        run_random("b2b", 1000, 100);
        run_random("bp", 1000, 50);

        run_small("slice_carry", 32'h0000_FFFF, 32'd1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        run_small("small_sub", 32'd0, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_small("small_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
